// File: rtl/oled_frame_scheduler.sv
// oled_frame_scheduler: snapshots a ROWS x COLS character buffer, optionally
// overlays a blinking cursor glyph, and hands one frame per pending update to
// OLEDInterface through its enable/done handshake.
module oled_frame_scheduler #(
    parameter int         ROWS        = 4,
    parameter int         COLS        = 16,
    parameter int         BLINK_DIV   = 25000000,
    parameter logic [7:0] CURSOR_CHAR = 8'h5F,
    parameter int         RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int         CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ROWS*COLS*8-1:0] msg,
    input  logic                   msg_valid,
    input  logic                   hl_en,
    input  logic [RW-1:0]          hl_row,
    input  logic [CW-1:0]          hl_col,
    input  logic                   oled_done,
    output logic                   oled_enable,
    output logic [ROWS*COLS*8-1:0] frame,
    output logic                   busy,
    output logic [15:0]            led,
    output logic [15:0]            frame_count
);

    localparam int CELLS = ROWS * COLS;
    localparam int FW    = CELLS * 8;
    localparam int BW    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SEND,
        RELEASE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;
    logic            blink_wrap;

    logic            hl_en_q;
    logic [RW-1:0]   hl_row_q;
    logic [CW-1:0]   hl_col_q;

    logic            update_event;
    logic            pending;
    logic [FW-1:0]   latch_frame;

    // The blink half-period ends on the last count; the phase flips there.
    assign blink_wrap = hl_en && (blink_cnt == BW'(BLINK_DIV - 1));

    // Anything that can change what is on screen marks a refresh as needed.
    assign update_event = msg_valid
                        | blink_wrap
                        | (hl_en  != hl_en_q)
                        | (hl_row != hl_row_q)
                        | (hl_col != hl_col_q);

    // Blink timer runs only while the cursor is enabled, otherwise parks at 0/off.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!hl_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    // Previous-cycle copies of the cursor controls, used for change detection and led.
    always_ff @(posedge clk) begin
        if (reset) begin
            hl_en_q  <= 1'b0;
            hl_row_q <= '0;
            hl_col_q <= '0;
        end else begin
            hl_en_q  <= hl_en;
            hl_row_q <= hl_row;
            hl_col_q <= hl_col;
        end
    end

    // Sticky refresh request; a new event in the latch cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b1;
        end else if (update_event) begin
            pending <= 1'b1;
        end else if (state == LATCH) begin
            pending <= 1'b0;
        end
    end

    // Build the frame to be latched: message with the cursor glyph at the highlight cell.
    always_comb begin
        latch_frame = msg;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (hl_en && blink_phase && (hl_row == RW'(r)) && (hl_col == CW'(c))) begin
                    latch_frame[(CELLS - 1 - (r * COLS + c)) * 8 +: 8] = CURSOR_CHAR;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_next  = state;
        oled_enable = 1'b0;
        busy        = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (pending) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                state_next = SEND;
            end
            SEND: begin
                oled_enable = 1'b1;
                if (oled_done) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!oled_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame snapshot is taken only in LATCH; completed frames are counted on done.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame       <= {CELLS{8'h20}};
            frame_count <= 16'd0;
        end else begin
            if (state == LATCH) begin
                frame <= latch_frame;
            end
            if ((state == SEND) && oled_done) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // One-hot column indicator from the registered cursor controls.
    always_comb begin
        led = 16'd0;
        for (int c = 0; c < COLS; c++) begin
            if (hl_en_q && (hl_col_q == CW'(c))) begin
                led[c] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// tb_oled_frame_scheduler: randomized scenarios against a behavioural model of
// the frame scheduler, with a modelled OLEDInterface answering each enable.
module tb_oled_frame_scheduler;

    localparam int ROWS  = 4;
    localparam int COLS  = 16;
    localparam int BDIV  = 8;
    localparam int FW    = ROWS * COLS * 8;
    localparam int ROWS2 = 3;
    localparam int COLS2 = 10;
    localparam int FW2   = ROWS2 * COLS2 * 8;

    logic           clk = 1'b0;
    logic           reset;

    logic [FW-1:0]  msg;
    logic           msg_valid;
    logic           hl_en;
    logic [1:0]     hl_row;
    logic [3:0]     hl_col;
    logic           oled_done;
    logic           oled_enable;
    logic [FW-1:0]  frame;
    logic           busy;
    logic [15:0]    led;
    logic [15:0]    frame_count;

    logic [FW2-1:0] msg2;
    logic           msg_valid2;
    logic           hl_en2;
    logic [1:0]     hl_row2;
    logic [3:0]     hl_col2;
    logic           oled_done2;
    logic           oled_enable2;
    logic [FW2-1:0] frame2;
    logic           busy2;
    logic [15:0]    led2;
    logic [15:0]    frame_count2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int done_delay = 5;
    int resp_cnt   = 0;
    int resp_cnt2  = 0;

    logic [FW-1:0]  cap_q[$];
    int             rise_q[$];
    int             len_q[$];
    int             viol = 0;
    bit             mon_prev = 1'b0;
    logic [FW-1:0]  mon_frame;
    int             mon_len = 0;

    logic [FW2-1:0] cap2_q[$];
    int             viol2 = 0;
    bit             mon_prev2 = 1'b0;
    logic [FW2-1:0] mon_frame2;

    oled_frame_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .BLINK_DIV(BDIV), .CURSOR_CHAR(8'h5F)
    ) dut (
        .clk(clk), .reset(reset), .msg(msg), .msg_valid(msg_valid),
        .hl_en(hl_en), .hl_row(hl_row), .hl_col(hl_col), .oled_done(oled_done),
        .oled_enable(oled_enable), .frame(frame), .busy(busy), .led(led),
        .frame_count(frame_count)
    );

    oled_frame_scheduler #(
        .ROWS(ROWS2), .COLS(COLS2), .BLINK_DIV(BDIV), .CURSOR_CHAR(8'h5F)
    ) dut2 (
        .clk(clk), .reset(reset), .msg(msg2), .msg_valid(msg_valid2),
        .hl_en(hl_en2), .hl_row(hl_row2), .hl_col(hl_col2), .oled_done(oled_done2),
        .oled_enable(oled_enable2), .frame(frame2), .busy(busy2), .led(led2),
        .frame_count(frame_count2)
    );

    always #5 clk = ~clk;

    // Cycle stamp: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // OLEDInterface stand-in: one-cycle done after enable has been high done_delay cycles.
    initial begin
        oled_done = 1'b0;
        forever begin
            @(negedge clk);
            if (oled_done) begin
                oled_done = 1'b0;
            end else if (oled_enable) begin
                resp_cnt++;
                if (resp_cnt >= done_delay) begin
                    oled_done = 1'b1;
                    resp_cnt  = 0;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // Same stand-in for the 3x10 instance.
    initial begin
        oled_done2 = 1'b0;
        forever begin
            @(negedge clk);
            if (oled_done2) begin
                oled_done2 = 1'b0;
            end else if (oled_enable2) begin
                resp_cnt2++;
                if (resp_cnt2 >= done_delay) begin
                    oled_done2 = 1'b1;
                    resp_cnt2  = 0;
                end
            end else begin
                resp_cnt2 = 0;
            end
        end
    end

    // Frame monitor: records each presented frame, its start cycle and enable width.
    initial begin
        forever begin
            @(negedge clk);
            if (oled_enable && !mon_prev) begin
                cap_q.push_back(frame);
                rise_q.push_back(cyc);
                mon_len = 1;
            end else if (oled_enable) begin
                mon_len++;
                if (frame !== mon_frame) viol++;
            end else if (mon_prev) begin
                len_q.push_back(mon_len);
            end
            mon_prev  = oled_enable;
            mon_frame = frame;
            if (oled_enable2 && !mon_prev2) begin
                cap2_q.push_back(frame2);
            end else if (oled_enable2 && (frame2 !== mon_frame2)) begin
                viol2++;
            end
            mon_prev2  = oled_enable2;
            mon_frame2 = frame2;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached, expected completion");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [FW-1:0] spaces();
        return {(ROWS * COLS){8'h20}};
    endfunction

    function automatic logic [FW-1:0] rand_msg();
        logic [FW-1:0] m;
        for (int i = 0; i < FW / 32; i++) m[i * 32 +: 32] = $urandom;
        return m;
    endfunction

    // Reference: displayed frame is the message with the cursor glyph on cell r*COLS+c.
    function automatic logic [FW-1:0] expect_frame(input logic [FW-1:0] m, input bit en,
                                                   input bit ph, input int r, input int c);
        logic [FW-1:0] f;
        f = m;
        if (en && ph && r < ROWS && c < COLS) f[(ROWS * COLS - 1 - (r * COLS + c)) * 8 +: 8] = 8'h5F;
        return f;
    endfunction

    // Reference: blink phase after edge t when the cursor was enabled on edges start..stop.
    function automatic bit phase_after(input int t, input int start, input int stop);
        if (t < start || t > stop) return 1'b0;
        return (((t - start + 1) / BDIV) % 2) == 1;
    endfunction

    task automatic wait_quiet(output bit ok);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 12 && n < 1000) begin
            @(negedge clk);
            n++;
            if (!busy && !busy2) quiet++;
            else quiet = 0;
        end
        ok = (quiet >= 12);
    endtask

    task automatic wait_enable(output bit ok);
        int n;
        n = 0;
        while (!oled_enable && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = oled_enable;
    endtask

    task automatic test_reset();
        bit ok;
        int c0;
        reset = 1'b1;
        msg = spaces(); msg_valid = 1'b0; hl_en = 1'b0; hl_row = 2'd0; hl_col = 4'd0;
        msg2 = {(ROWS2 * COLS2){8'h20}}; msg_valid2 = 1'b0; hl_en2 = 1'b0; hl_row2 = 2'd0; hl_col2 = 4'd0;
        repeat (3) @(negedge clk);
        total++; if (oled_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_enable got %b want 0", oled_enable); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_count got %0d want 0", frame_count); end
        total++; if (frame !== spaces()) begin bad++; $display("[TB] FAIL reset_frame got %h want spaces", frame); end
        total++; if (led !== 16'd0) begin bad++; $display("[TB] FAIL reset_led got %h want 0", led); end
        cap_q.delete(); rise_q.delete(); len_q.delete();
        c0 = cyc;
        reset = 1'b0;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL reset_timeout got busy want idle"); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("[TB] FAIL first_count got %0d want 1", frame_count); end
        total++; if (cap_q.size() !== 1) begin bad++; $display("[TB] FAIL first_frames got %0d want 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            total++; if (cap_q[0] !== spaces()) begin bad++; $display("[TB] FAIL first_frame got %h want spaces", cap_q[0]); end
            total++; if (rise_q[0] !== c0 + 2) begin bad++; $display("[TB] FAIL first_latency got %0d want %0d", rise_q[0], c0 + 2); end
        end
        if (len_q.size() > 0) begin
            total++; if (len_q[0] !== 5) begin bad++; $display("[TB] FAIL first_enable_width got %0d want 5", len_q[0]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL first_busy got %b want 0", busy); end
    endtask

    task automatic test_message();
        bit ok;
        int c0;
        logic [15:0] fc0;
        logic [FW-1:0] expv;
        for (int it = 0; it < 3; it++) begin
            cap_q.delete(); rise_q.delete();
            fc0 = frame_count;
            @(negedge clk);
            msg = rand_msg();
            msg[FW-1 -: 128] = "MINESWEEPER 4x16";
            expv = expect_frame(msg, 1'b0, 1'b0, 0, 0);
            msg_valid = 1'b1;
            c0 = cyc;
            @(negedge clk);
            msg_valid = 1'b0;
            wait_quiet(ok);
            total++; if (!ok) begin bad++; $display("[TB] FAIL msg_timeout[%0d] got busy want idle", it); end
            total++; if (cap_q.size() !== 1) begin bad++; $display("[TB] FAIL msg_frames[%0d] got %0d want 1", it, cap_q.size()); end
            if (cap_q.size() > 0) begin
                total++; if (cap_q[0] !== expv) begin bad++; $display("[TB] FAIL msg_frame[%0d] got %h want %h", it, cap_q[0], expv); end
                total++; if (rise_q[0] !== c0 + 3) begin bad++; $display("[TB] FAIL msg_latency[%0d] got %0d want %0d", it, rise_q[0], c0 + 3); end
            end
            total++; if (frame[FW-1 -: 8] !== 8'h4D) begin bad++; $display("[TB] FAIL msg_first_char[%0d] got %h want 4d", it, frame[FW-1 -: 8]); end
            total++; if (frame_count !== fc0 + 16'd1) begin bad++; $display("[TB] FAIL msg_count[%0d] got %0d want %0d", it, frame_count, fc0 + 16'd1); end
        end
        fc0 = frame_count;
        msg = rand_msg();
        repeat (20) @(negedge clk);
        total++; if (frame_count !== fc0) begin bad++; $display("[TB] FAIL silent_msg_count got %0d want %0d", frame_count, fc0); end
        total++; if (frame !== expv) begin bad++; $display("[TB] FAIL silent_msg_frame got %h want %h", frame, expv); end
    endtask

    task automatic test_blink();
        bit ok;
        int start;
        int stop;
        int r;
        bit en;
        logic [FW-1:0] expv;
        logic [FW-1:0] base;
        logic [FW-1:0] f1;
        cap_q.delete(); rise_q.delete();
        base = msg;
        @(negedge clk);
        hl_en = 1'b1; hl_row = 2'd2; hl_col = 4'd5;
        start = cyc + 1;
        repeat (60) @(negedge clk);
        total++; if (led !== 16'h0020) begin bad++; $display("[TB] FAIL blink_led got %h want 0020", led); end
        hl_en = 1'b0;
        stop = cyc;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL blink_timeout got busy want idle"); end
        total++; if (cap_q.size() < 7) begin bad++; $display("[TB] FAIL blink_frames got %0d want at least 7", cap_q.size()); end
        for (int i = 0; i < cap_q.size(); i++) begin
            r  = rise_q[i];
            en = (r - 1 >= start) && (r - 1 <= stop);
            expv = expect_frame(base, en, phase_after(r - 2, start, stop), 2, 5);
            total++; if (cap_q[i] !== expv) begin bad++; $display("[TB] FAIL blink_frame[%0d] got %h want %h", i, cap_q[i], expv); end
            if (i > 0 && i < cap_q.size() - 1) begin
                total++; if (rise_q[i] - rise_q[i-1] !== BDIV) begin bad++; $display("[TB] FAIL blink_period[%0d] got %0d want %0d", i, rise_q[i] - rise_q[i-1], BDIV); end
            end
        end
        if (cap_q.size() > 1) begin
            f1 = cap_q[1];
            total++; if (f1[(63 - 37) * 8 +: 8] !== 8'h5F) begin bad++; $display("[TB] FAIL blink_cursor_on got %h want 5f", f1[(63 - 37) * 8 +: 8]); end
        end
        total++; if (led !== 16'h0000) begin bad++; $display("[TB] FAIL blink_led_off got %h want 0000", led); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] fc0;
        logic [FW-1:0] a;
        logic [FW-1:0] c;
        cap_q.delete(); rise_q.delete();
        fc0 = frame_count;
        @(negedge clk);
        a = rand_msg();
        msg = a; msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        wait_enable(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_enable got 0 want 1"); end
        @(negedge clk);
        msg = rand_msg(); msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        @(negedge clk);
        c = rand_msg();
        msg = c; msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_timeout got busy want idle"); end
        total++; if (frame_count !== fc0 + 16'd2) begin bad++; $display("[TB] FAIL b2b_count got %0d want %0d", frame_count, fc0 + 16'd2); end
        total++; if (cap_q.size() !== 2) begin bad++; $display("[TB] FAIL b2b_frames got %0d want 2", cap_q.size()); end
        if (cap_q.size() >= 2) begin
            total++; if (cap_q[0] !== a) begin bad++; $display("[TB] FAIL b2b_first got %h want %h", cap_q[0], a); end
            total++; if (cap_q[1] !== c) begin bad++; $display("[TB] FAIL b2b_second got %h want %h", cap_q[1], c); end
        end
    endtask

    task automatic test_range();
        bit ok;
        logic [15:0] exp_led;
        logic [FW2-1:0] m2;
        cap2_q.delete();
        @(negedge clk);
        for (int i = 0; i < ROWS2 * COLS2; i++) m2[i * 8 +: 8] = 8'($urandom_range(32, 126));
        msg2 = m2; msg_valid2 = 1'b1;
        @(negedge clk);
        msg_valid2 = 1'b0;
        hl_en2 = 1'b1; hl_row2 = 2'd3; hl_col2 = 4'd4;
        repeat (40) @(negedge clk);
        hl_en2 = 1'b0;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL range_timeout got busy want idle"); end
        total++; if (cap2_q.size() < 4) begin bad++; $display("[TB] FAIL range_frames got %0d want at least 4", cap2_q.size()); end
        for (int i = 0; i < cap2_q.size(); i++) begin
            total++; if (cap2_q[i] !== m2) begin bad++; $display("[TB] FAIL range_frame[%0d] got %h want %h", i, cap2_q[i], m2); end
        end
        hl_en2 = 1'b1; hl_row2 = 2'd0;
        for (int c = 0; c < 16; c++) begin
            hl_col2 = 4'(c);
            @(negedge clk);
            exp_led = (c < COLS2) ? (16'd1 << c) : 16'd0;
            total++; if (led2 !== exp_led) begin bad++; $display("[TB] FAIL range_led[%0d] got %h want %h", c, led2, exp_led); end
        end
        hl_en2 = 1'b0;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL range_sweep_timeout got busy want idle"); end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        @(negedge clk);
        msg = rand_msg(); msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        wait_enable(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL midrst_enable got 0 want 1"); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        msg = spaces();
        @(negedge clk);
        total++; if (oled_enable !== 1'b0) begin bad++; $display("[TB] FAIL midrst_enable_drop got %b want 0", oled_enable); end
        total++; if (frame !== spaces()) begin bad++; $display("[TB] FAIL midrst_frame got %h want spaces", frame); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL midrst_count got %0d want 0", frame_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        cap_q.delete(); rise_q.delete(); len_q.delete();
        reset = 1'b0;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL midrst_timeout got busy want idle"); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("[TB] FAIL midrst_new_count got %0d want 1", frame_count); end
        total++; if (cap_q.size() !== 1) begin bad++; $display("[TB] FAIL midrst_frames got %0d want 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            total++; if (cap_q[0] !== spaces()) begin bad++; $display("[TB] FAIL midrst_blank got %h want spaces", cap_q[0]); end
        end
    endtask

    // Scenario sequence followed by the frame-stability checks and the summary.
    initial begin
        $display("[TB] oled_frame_scheduler bench start");
        test_reset();
        test_message();
        test_blink();
        test_back_to_back();
        test_range();
        test_reset_mid_send();
        total++; if (viol !== 0) begin bad++; $display("[TB] FAIL frame_stable got %0d changes want 0", viol); end
        total++; if (viol2 !== 0) begin bad++; $display("[TB] FAIL frame2_stable got %0d changes want 0", viol2); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
